// File: rtl/irq_svc_pkg.sv
// Shared definitions for the interrupt service sequencer: FSM state
// encoding, AXI response codes and the HOLDOFF / timeout lengths.
package irq_svc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    HOLDOFF = 3'd5
  } svc_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // HOLDOFF dwell time, and the per-state wait limit used when the
  // optional timeout is built in.
  localparam int HOLDOFF_CYCLES = 2;
  localparam int TIMEOUT_CYCLES = 16;

  // Per-state cycle timer width; wide enough for both limits above.
  localparam int TIMER_WIDTH = 5;

  function automatic logic resp_is_okay(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/irq_service_sequencer.sv
// Interrupt service sequencer: on a level irq it reads the interrupt
// status register over AXI4-Lite, writes any nonzero status back to the
// acknowledge register, counts completed acknowledges and then holds off
// for a couple of cycles before sampling irq again.
// Optional build macro: IRQ_SVC_TIMEOUT_EN adds a per-state wait limit
// that abandons a stuck transfer, flags err and goes to HOLDOFF.
module irq_service_sequencer
  import irq_svc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] ISR_ADDR   = 5'h10,
  parameter logic [ADDR_WIDTH-1:0] IAR_ADDR   = 5'h0C
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  irq,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [15:0]           svc_count,
  output logic [31:0]           last_status,
  output logic                  err
);

  localparam logic [TIMER_WIDTH-1:0] HOLDOFF_LAST = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);
`ifdef IRQ_SVC_TIMEOUT_EN
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

  svc_state_e             state_reg,       state_next;
  logic                   arvalid_reg,     arvalid_next;
  logic                   rready_reg,      rready_next;
  logic                   awvalid_reg,     awvalid_next;
  logic                   wvalid_reg,      wvalid_next;
  logic                   bready_reg,      bready_next;
  logic                   aw_done_reg,     aw_done_next;
  logic                   w_done_reg,      w_done_next;
  logic [31:0]            status_reg,      status_next;
  logic [15:0]            svc_count_reg,   svc_count_next;
  logic [31:0]            last_status_reg, last_status_next;
  logic                   err_reg,         err_next;
  logic [TIMER_WIDTH-1:0] tmr_reg,         tmr_next;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_reg && m_axi_awready;
  assign w_hs  = wvalid_reg && m_axi_wready;

  // Addresses are fixed; valids/readies come straight from registers so
  // nothing handed to the slave depends combinationally on its readies.
  assign m_axi_araddr  = ISR_ADDR;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;
  assign m_axi_awaddr  = IAR_ADDR;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = status_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign svc_count     = svc_count_reg;
  assign last_status   = last_status_reg;
  assign err           = err_reg;

  // State and handshake-control registers; reset drops every valid/ready at once.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_reg       <= IDLE;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      status_reg      <= '0;
      svc_count_reg   <= '0;
      last_status_reg <= '0;
      err_reg         <= 1'b0;
      tmr_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      bready_reg      <= bready_next;
      aw_done_reg     <= aw_done_next;
      w_done_reg      <= w_done_next;
      status_reg      <= status_next;
      svc_count_reg   <= svc_count_next;
      last_status_reg <= last_status_next;
      err_reg         <= err_next;
      tmr_reg         <= tmr_next;
    end
  end

  // Next-state logic: each transition also sets the registered valids/readies for the state it enters.
  always_comb begin
    state_next       = state_reg;
    arvalid_next     = arvalid_reg;
    rready_next      = rready_reg;
    awvalid_next     = awvalid_reg;
    wvalid_next      = wvalid_reg;
    bready_next      = bready_reg;
    aw_done_next     = aw_done_reg;
    w_done_next      = w_done_reg;
    status_next      = status_reg;
    svc_count_next   = svc_count_reg;
    last_status_next = last_status_reg;
    err_next         = err_reg;
    tmr_next         = tmr_reg;

    case (state_reg)
      IDLE: begin
        if (irq) begin
          state_next   = RD_ADDR;
          arvalid_next = 1'b1;
        end
      end

      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_next = 1'b0;
          status_next = m_axi_rdata;
          if (!resp_is_okay(m_axi_rresp)) begin
            err_next   = 1'b1;
            state_next = HOLDOFF;
          end else if (m_axi_rdata == 32'd0) begin
            // Nothing pending: no acknowledge needed.
            state_next = HOLDOFF;
          end else begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        // Address and data channels complete independently, in either order.
        if (aw_hs) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_next = 1'b0;
          state_next  = HOLDOFF;
          if (resp_is_okay(m_axi_bresp)) begin
            svc_count_next   = svc_count_reg + 16'd1;
            last_status_next = status_reg;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      HOLDOFF: begin
        // Gives the peripheral time to drop irq before it is sampled again.
        if (tmr_reg == HOLDOFF_LAST) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef IRQ_SVC_TIMEOUT_EN
    // Abandon a transfer that has made no progress for the full wait limit.
    if ((state_reg == RD_ADDR || state_reg == RD_DATA ||
         state_reg == WR_REQ  || state_reg == WR_RESP) &&
        (state_next == state_reg) && (tmr_reg == TIMEOUT_LAST)) begin
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      awvalid_next = 1'b0;
      wvalid_next  = 1'b0;
      bready_next  = 1'b0;
      err_next     = 1'b1;
      state_next   = HOLDOFF;
    end
`endif

    // Cycles spent in the current state; restarts on every transition, saturates.
    if (state_next != state_reg) begin
      tmr_next = '0;
    end else if (tmr_reg != '1) begin
      tmr_next = tmr_reg + 1'b1;
    end
  end

endmodule
